note_scheduler: RTL and testbench
=================================

Name: note_scheduler

Overview:
- Round-robin scheduler that shares the single square-wave tone generator (octave/note divider chain driving the speaker) between NUM_REQ requesters, e.g. melody ROM player, alarm, key-click.
- Accepts one {fullnote, duration} request at a time and drives the generator's 8-bit fullnote input for duration x TICK_DIV clocks.
- Inserts a silent inter-note gap after each note, then reports completion.
- Sits between the requesting blocks and the tone generator; the generator treats fullnote==0 as silence.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TICK_DIV, 4194304, clocks per duration unit (2^22, matches song pace at 25 MHz)
- GAP_TICKS, 1, silent duration units after every note (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request per channel; data held stable while high
- req_note  in  8*NUM_REQ  channel i fullnote at [8i+7:8i]; bits[5:0] = octave*12+note; 0 = rest
- req_dur  in  8*NUM_REQ  channel i duration in ticks at [8i+7:8i]
- stop  in  1  synchronous abort of the current note
- ack  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- fullnote  out  8  to tone generator
- busy  out  1  high when not IDLE
- grant_id  out  clog2(NUM_REQ)  channel being served / last served
- done  out  1  one-cycle pulse when a note and its gap complete

Behaviour:
- Reset values (async): state IDLE; ack=0, fullnote=0, busy=0, grant_id=0, done=0; tick counter=0; remaining=0; last_grant=NUM_REQ-1, so channel 0 has first priority.
- All outputs are registered. Precedence: reset > stop > state machine.
- IDLE:
  - At an edge with any req high, grant the first requesting channel searching from last_grant+1, with wrap-around.
  - Same edge: state<=PLAY, ack[g]<=1, grant_id<=g, last_grant<=g, remaining<=req_dur[g], tick counter<=0.
  - fullnote<=req_note[g] if req_dur[g]!=0, else 0.
  - ack is high for exactly the cycle after the granting edge.
  - Requester must drop or replace req in the cycle after ack. A req still high when the scheduler next reaches IDLE is a new request.
- Tick: counter counts 0..TICK_DIV-1 and restarts at 0 on every state entry. Tick = counter==TICK_DIV-1.
- PLAY:
  - On tick, remaining decrements.
  - On the tick where remaining==1, or at the first edge if remaining==0: state<=GAP, fullnote<=0, remaining<=GAP_TICKS, counter<=0.
  - fullnote is therefore held for exactly dur*TICK_DIV cycles. A zero-duration request stays in PLAY one cycle with fullnote=0.
  - note==0 with dur>0 is a timed rest; it is scheduled normally.
- GAP:
  - fullnote=0; counts GAP_TICKS ticks.
  - At the final tick: state<=IDLE, done<=1 for one cycle, grant_id unchanged.
  - The cycle done is high is an IDLE cycle, so arbitration may grant at the next edge: back-to-back notes with no idle cycle are allowed.
- stop:
  - In PLAY or GAP: next edge state<=IDLE, fullnote<=0, busy<=0, no done, no ack that edge; last_grant kept.
  - In IDLE: no grant that edge.
- busy is high in every cycle that state!=IDLE.
- Widths:
  - remaining is 8 bits.
  - The tick counter is clog2(TICK_DIV) bits.
  - No overflow is possible: max note = 255*TICK_DIV cycles.

Decomposition:
- Shared package holds: state encoding constants (IDLE, PLAY, GAP), NOTE_W=8, DUR_W=8, the default TICK_DIV, and the NOTE_REST=0 constant.
- One natural sub-module: rr_arbiter (combinational round-robin pick from req and last_grant, returns grant index and valid).
- Tick counter and FSM stay in note_scheduler.

Test Plan:
Bench parameters TICK_DIV=4, GAP_TICKS=1, NUM_REQ=4.
- Single request:
  - Stimulus: after reset, req[2] with note 8'h1B, dur 3.
  - Response: ack=4'b0100 for one cycle; fullnote=8'h1B for 12 cycles; then 0 for 4 cycles; done pulse with grant_id=2; busy high for 16 cycles.
- Round-robin order:
  - Stimulus: req[0] and req[3] held, each re-presented after ack.
  - Response: grant order 0,3,0,3. Then with last_grant=1 and req[1], req[3] high, channel 3 is granted first.
- Zero duration:
  - Stimulus: req[1] with note 8'h20, dur 0.
  - Response: ack; fullnote stays 0; busy for 1+4 cycles; done with grant_id=1.
- Stop in PLAY:
  - Stimulus: stop asserted during PLAY (dur 10), with req[2] pending.
  - Response: next cycle fullnote=0, busy=0, no done; req[2] acked at the following edge.
- Async reset mid-GAP:
  - Stimulus: reset asserted mid-GAP.
  - Response: all outputs 0 immediately, without waiting for clk. After release, simultaneous req[0] and req[1] grant channel 0.
- Back-to-back:
  - Stimulus: req[0] held continuously, data changed after each ack.
  - Response: the new ack arrives the cycle after the done cycle; no extra idle cycle between notes.

Source files
------------

// File: rtl/note_scheduler_pkg.sv
// Shared types and constants for the note scheduler and its arbiter.
package note_scheduler_pkg;

  localparam int NOTE_W       = 8;
  localparam int DUR_W        = 8;
  localparam int DEF_TICK_DIV = 4194304;

  // A fullnote of zero silences the tone generator.
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Requester / tone-generator side bundle of the note scheduler.
// master: requesting blocks and generator; slave: the scheduler.
interface note_scheduler_if
  import note_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int ID_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NOTE_W*NUM_REQ-1:0] req_note;
  logic [DUR_W*NUM_REQ-1:0]  req_dur;
  logic                      stop;
  logic [NUM_REQ-1:0]        ack;
  logic [NOTE_W-1:0]         fullnote;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      done;

  modport master (
    output req, req_note, req_dur, stop,
    input  ack, fullnote, busy, grant_id, done
  );

  modport slave (
    input  req, req_note, req_dur, stop,
    output ack, fullnote, busy, grant_id, done
  );

endinterface

// File: rtl/note_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after last_grant,
// wrapping around.
module note_scheduler_rr_arbiter
  import note_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant,
  output logic               valid
);

  logic [ID_W-1:0] cand;

  // Walk the channels starting just after the previous winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Round-robin scheduler sharing one square-wave tone generator between
// NUM_REQ requesters. Plays each accepted note for dur*TICK_DIV clocks,
// follows it with GAP_TICKS silent ticks, then pulses done.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int GAP_TICKS = 1
) (
  input logic             clk,
  input logic             reset,
  note_scheduler_if.slave bus
);

  localparam int ID_W  = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_TICKS);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DUR_W-1:0]  remaining;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick;
  logic              pick_valid;
  logic [NOTE_W-1:0] pick_note;
  logic [DUR_W-1:0]  pick_dur;
  logic              tick;

  note_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (bus.req),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  // Select the winning channel's note and duration fields.
  always_comb begin
    pick_note = NOTE_REST;
    pick_dur  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) begin
        pick_note = bus.req_note[i*NOTE_W +: NOTE_W];
        pick_dur  = bus.req_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  assign tick = (cnt == CNT_LAST);

  // Scheduler FSM with tick counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      remaining    <= '0;
      last_grant   <= ID_W'(NUM_REQ - 1);
      bus.ack      <= '0;
      bus.fullnote <= NOTE_REST;
      bus.busy     <= 1'b0;
      bus.grant_id <= '0;
      bus.done     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      bus.ack  <= '0;
      bus.done <= 1'b0;
      if (bus.stop) begin
        // Abort any note in progress; in IDLE this just suppresses the grant.
        state        <= IDLE;
        cnt          <= '0;
        bus.fullnote <= NOTE_REST;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pick_valid) begin
              state         <= PLAY;
              bus.ack[pick] <= 1'b1;
              bus.grant_id  <= pick;
              last_grant    <= pick;
              remaining     <= pick_dur;
              cnt           <= '0;
              bus.busy      <= 1'b1;
              bus.fullnote  <= (pick_dur != '0) ? pick_note : NOTE_REST;
            end
          end

          PLAY: begin
            // Zero duration leaves after one cycle; otherwise on the last tick.
            if (remaining == '0 || (tick && remaining == DUR_ONE)) begin
              state        <= GAP;
              bus.fullnote <= NOTE_REST;
              remaining    <= GAP_LOAD;
              cnt          <= '0;
            end else if (tick) begin
              remaining <= remaining - DUR_ONE;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          GAP: begin
            if (tick && remaining == DUR_ONE) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              cnt      <= '0;
            end else if (tick) begin
              remaining <= remaining - DUR_ONE;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.fullnote <= NOTE_REST;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Randomized and directed bench for note_scheduler, checked every cycle
// against a timeline model of grant / note end / gap end instants.
module tb_note_scheduler;
  import note_scheduler_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int ID_W      = idx_w(NUM_REQ);
  localparam int QD        = 32;

  logic clk = 1'b0;
  logic reset;

  note_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  note_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .TICK_DIV  (TICK_DIV),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (timeline of each note) ----------------
  logic [NUM_REQ-1:0] exp_ack  = '0;
  logic [7:0]         exp_note = '0;
  logic               exp_busy = 1'b0;
  logic               exp_done = 1'b0;
  logic [ID_W-1:0]    exp_gid  = '0;
  int                 edge_n   = 0;
  int                 m_play_end, m_end, m_last, m_c;
  bit                 m_active = 1'b0;
  logic [7:0]         m_note, m_dur;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_last   = NUM_REQ - 1;
      exp_ack  = '0;
      exp_note = '0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_gid  = '0;
    end else begin
      edge_n++;
      exp_ack  = '0;
      exp_done = 1'b0;
      if (m_active) begin
        if (bus.stop) m_active = 1'b0;
        else if (edge_n == m_end) begin
          m_active = 1'b0;
          exp_done = 1'b1;
        end
      end else if (!bus.stop && bus.req != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_c = (m_last + k) % NUM_REQ;
          if (!m_active && bus.req[m_c]) begin
            m_active     = 1'b1;
            m_last       = m_c;
            exp_gid      = ID_W'(m_c);
            exp_ack[m_c] = 1'b1;
            m_note       = bus.req_note[m_c*8 +: 8];
            m_dur        = bus.req_dur[m_c*8 +: 8];
            m_play_end   = edge_n + ((m_dur == 0) ? 1 : int'(m_dur) * TICK_DIV);
            m_end        = m_play_end + GAP_TICKS * TICK_DIV;
          end
        end
      end
      exp_busy = m_active;
      exp_note = (m_active && edge_n < m_play_end && m_dur != 0) ? m_note : 8'h00;
    end
  end

  // ---------------- requester queues ----------------
  logic [15:0] job [NUM_REQ][QD];
  int head [NUM_REQ];
  int tail [NUM_REQ];
  int ack_log [$];
  int cyc = 0;
  bit prev_done = 1'b0;
  int n_b2b = 0;

  task automatic push(input int ch, input logic [7:0] note, input logic [7:0] dur);
    job[ch][tail[ch] % QD] = {note, dur};
    tail[ch]++;
  endtask

  task automatic drive_reqs();
    for (int ch = 0; ch < NUM_REQ; ch++) begin
      if (head[ch] < tail[ch]) begin
        bus.req[ch]             = 1'b1;
        bus.req_note[ch*8 +: 8] = job[ch][head[ch] % QD][15:8];
        bus.req_dur[ch*8 +: 8]  = job[ch][head[ch] % QD][7:0];
      end else begin
        bus.req[ch] = 1'b0;
      end
    end
  endtask

  function automatic bit queues_empty();
    for (int ch = 0; ch < NUM_REQ; ch++)
      if (head[ch] < tail[ch]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: compare against the model on the falling edge, then update requesters.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("ack", bus.ack, exp_ack);
    check("fullnote", bus.fullnote, exp_note);
    check("busy", bus.busy, exp_busy);
    check("done", bus.done, exp_done);
    check("grant_id", bus.grant_id, exp_gid);
    if (bus.ack != '0 && prev_done) n_b2b++;
    prev_done = bus.done;
    for (int ch = 0; ch < NUM_REQ; ch++) begin
      if (bus.ack[ch]) begin
        head[ch]++;
        ack_log.push_back(ch);
      end
    end
    drive_reqs();
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      if (!bus.busy && bus.ack == '0 && queues_empty()) ok = 1'b1;
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic wait_ack(input int ch, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      if (bus.ack[ch]) ok = 1'b1;
    end
    check("ack_timeout", ok, 1);
  endtask

  task automatic observe(input int n, output logic [NUM_REQ-1:0] ack_or, output int nz,
                         output int busy_n, output int done_n, output logic [ID_W-1:0] gid);
    ack_or = '0; nz = 0; busy_n = 0; done_n = 0; gid = '0;
    repeat (n) begin
      cycle();
      ack_or |= bus.ack;
      if (bus.fullnote != 8'h00) nz++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        gid = bus.grant_id;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [NUM_REQ-1:0] o_ack;
  int o_nz, o_busy, o_done, rch;
  logic [ID_W-1:0] o_gid;
  int rr_exp [4] = '{0, 3, 0, 3};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_note = '0;
    bus.req_dur  = '0;
    bus.stop     = 1'b0;
    for (int ch = 0; ch < NUM_REQ; ch++) begin
      head[ch] = 0;
      tail[ch] = 0;
    end
    #7;
    check("rst_ack", bus.ack, 0);
    check("rst_fullnote", bus.fullnote, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin between channels 0 and 3 from reset priority.
    push(0, 8'h11, 1); push(0, 8'h12, 1);
    push(3, 8'h31, 1); push(3, 8'h32, 1);
    ack_log.delete();
    wait_idle(200);
    check("rr_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) check("rr_order", ack_log[i], rr_exp[i]);

    // Single request on channel 2.
    push(2, 8'h1B, 3);
    observe(30, o_ack, o_nz, o_busy, o_done, o_gid);
    check("single_ack", o_ack, 4'b0100);
    check("single_note_cycles", o_nz, 12);
    check("single_busy_cycles", o_busy, 16);
    check("single_done", o_done, 1);
    check("single_gid", o_gid, 2);

    // Zero-duration request on channel 1.
    push(1, 8'h20, 0);
    observe(20, o_ack, o_nz, o_busy, o_done, o_gid);
    check("zero_ack", o_ack, 4'b0010);
    check("zero_note_cycles", o_nz, 0);
    check("zero_busy_cycles", o_busy, 5);
    check("zero_done", o_done, 1);
    check("zero_gid", o_gid, 1);

    // last_grant=1 with channels 1 and 3 requesting: 3 wins first.
    push(1, 8'h41, 1); push(3, 8'h43, 1);
    ack_log.delete();
    wait_idle(200);
    check("rr_wrap_count", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      check("rr_wrap_first", ack_log[0], 3);
      check("rr_wrap_second", ack_log[1], 1);
    end

    // Stop during PLAY with channel 2 pending.
    push(0, 8'h55, 10);
    wait_ack(0, 20);
    push(2, 8'h66, 1);
    drive_reqs();
    repeat (5) cycle();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    check("stop_fullnote", bus.fullnote, 0);
    check("stop_busy", bus.busy, 0);
    check("stop_done", bus.done, 0);
    check("stop_ack", bus.ack, 0);
    head[0] = tail[0];
    drive_reqs();
    cycle();
    check("stop_next_ack", bus.ack, 4'b0100);
    wait_idle(200);

    // Async reset in the middle of the gap.
    push(1, 8'h12, 1);
    wait_ack(1, 20);
    repeat (5) cycle();
    check("gap_busy", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ack", bus.ack, 0);
    check("arst_fullnote", bus.fullnote, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_grant_id", bus.grant_id, 0);
    check("arst_done", bus.done, 0);
    for (int ch = 0; ch < NUM_REQ; ch++) head[ch] = tail[ch];
    drive_reqs();
    @(negedge clk);
    reset = 1'b0;
    prev_done = 1'b0;
    push(0, 8'h01, 1); push(1, 8'h02, 1);
    drive_reqs();
    ack_log.delete();
    wait_idle(200);
    check("post_reset_first", (ack_log.size() > 0) ? ack_log[0] : -1, 0);

    // Back-to-back notes on channel 0.
    n_b2b = 0;
    push(0, 8'hA1, 1); push(0, 8'hA2, 2); push(0, 8'hA3, 0);
    wait_idle(200);
    check("back_to_back", n_b2b, 2);

    // Randomized traffic with occasional stops.
    repeat (60) begin
      rch = $urandom_range(0, NUM_REQ - 1);
      if (tail[rch] - head[rch] < 4) push(rch, 8'($urandom), 8'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 12)) begin
        bus.stop = ($urandom_range(0, 15) == 0);
        cycle();
      end
    end
    bus.stop = 1'b0;
    wait_idle(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
